alu_exec_ctrl: RTL and testbench

//  Multi-cycle execute stage that sits directly upstream of the 16-bit ALU.
//  - Decodes a 16-bit instruction and reads operands from an 8x16 register file.
//  - Drives the ALU inputs (inA/inB/inC/opc), captures the result and flags, and writes the result back.
//  - start/busy/done handshake toward the sequencer.

---
 rtl/alu_exec_pkg.sv | 26 ++
 rtl/alu_exec_regfile.sv | 43 ++++
 rtl/alu_exec_ctrl.sv | 151 +++++++++++++++
 tb/tb_alu_exec_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_pkg.sv
// Shared types and constants for the ALU execute-stage controller: FSM state
// encoding, ALU opcodes and instruction field positions.
package alu_exec_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        EXEC,
        WB
    } exec_state_t;

    localparam logic [2:0] OP_NEG  = 3'b000;
    localparam logic [2:0] OP_INC  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_PACK = 3'b110;
    localparam logic [2:0] OP_NOP  = 3'b111;

    localparam int OPC_MSB = 15;
    localparam int RD_MSB  = 12;
    localparam int RS_MSB  = 9;
    localparam int CIN_BIT = 6;

endpackage

// File: rtl/alu_exec_regfile.sv
// Register file for the execute stage: two combinational read ports, one
// synchronous write port. Build option ALU_EXEC_R0_ZERO_EN hardwires r0 to 0.
module alu_exec_regfile #(
    parameter int DATA_W = 16,
    parameter int REG_N  = 8,
    parameter int ADDR_W = $clog2(REG_N)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wrEn_i,
    input  logic [ADDR_W-1:0] wrAddr_i,
    input  logic [DATA_W-1:0] wrData_i,
    input  logic [ADDR_W-1:0] rdAddrA_i,
    output logic [DATA_W-1:0] rdDataA_o,
    input  logic [ADDR_W-1:0] rdAddrB_i,
    output logic [DATA_W-1:0] rdDataB_o
);

    logic [DATA_W-1:0] mem_q [REG_N];
    logic              wrAllowed;

`ifdef ALU_EXEC_R0_ZERO_EN
    // r0 keeps its storage but is masked on both sides, so it always reads 0.
    assign wrAllowed = wrEn_i && (wrAddr_i != '0);
    assign rdDataA_o = (rdAddrA_i == '0) ? '0 : mem_q[rdAddrA_i];
    assign rdDataB_o = (rdAddrB_i == '0) ? '0 : mem_q[rdAddrB_i];
`else
    assign wrAllowed = wrEn_i;
    assign rdDataA_o = mem_q[rdAddrA_i];
    assign rdDataB_o = mem_q[rdAddrB_i];
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < REG_N; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wrAllowed) begin
            mem_q[wrAddr_i] <= wrData_i;
        end
    end

endmodule

// File: rtl/alu_exec_ctrl.sv
// Multi-cycle execute stage feeding an external combinational ALU:
// IDLE -> READ -> EXEC -> WB. Optional build macro: ALU_EXEC_R0_ZERO_EN.
module alu_exec_ctrl
    import alu_exec_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int REG_N  = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [DATA_W-1:0]        instr_i,
    output logic                     busy_o,
    output logic                     done_o,
    input  logic                     extWrEn_i,
    input  logic [$clog2(REG_N)-1:0] extWrAddr_i,
    input  logic [DATA_W-1:0]        extWrData_i,
    output logic [DATA_W-1:0]        aluA_o,
    output logic [DATA_W-1:0]        aluB_o,
    output logic                     aluC_o,
    output logic [2:0]               aluOpc_o,
    input  logic [DATA_W-1:0]        aluW_i,
    input  logic                     aluZer_i,
    input  logic                     aluNeg_i,
    output logic [DATA_W-1:0]        result_o,
    output logic                     flagZ_o,
    output logic                     flagN_o
);

    localparam int ADDR_W = $clog2(REG_N);

    exec_state_t       state_q;
    logic [2:0]        opc_q;
    logic [ADDR_W-1:0] rd_q;
    logic [ADDR_W-1:0] rs_q;
    logic              cin_q;
    logic              busy_q;
    logic              done_q;
    logic [DATA_W-1:0] aluA_q;
    logic [DATA_W-1:0] aluB_q;
    logic              aluC_q;
    logic [2:0]        aluOpc_q;
    logic [DATA_W-1:0] result_q;
    logic              flagZ_q;
    logic              flagN_q;

    logic              wrEn_d;
    logic [ADDR_W-1:0] wrAddr_d;
    logic [DATA_W-1:0] wrData_d;
    logic [DATA_W-1:0] rdDataA;
    logic [DATA_W-1:0] rdDataB;
    logic [CIN_BIT-1:0] unusedInstrBits;

    assign unusedInstrBits = instr_i[CIN_BIT-1:0];

    // The single write port is shared: external writes own it in IDLE, writeback in WB.
    always_comb begin
        wrEn_d   = 1'b0;
        wrAddr_d = extWrAddr_i;
        wrData_d = extWrData_i;
        if (state_q == IDLE) begin
            wrEn_d = extWrEn_i;
        end else if (state_q == WB) begin
            wrEn_d   = (opc_q != OP_NOP);
            wrAddr_d = rd_q;
            wrData_d = result_q;
        end
    end

    alu_exec_regfile #(
        .DATA_W (DATA_W),
        .REG_N  (REG_N),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wrEn_i    (wrEn_d),
        .wrAddr_i  (wrAddr_d),
        .wrData_i  (wrData_d),
        .rdAddrA_i (rd_q),
        .rdDataA_o (rdDataA),
        .rdAddrB_i (rs_q),
        .rdDataB_o (rdDataB)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            opc_q    <= '0;
            rd_q     <= '0;
            rs_q     <= '0;
            cin_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            aluA_q   <= '0;
            aluB_q   <= '0;
            aluC_q   <= 1'b0;
            aluOpc_q <= '0;
            result_q <= '0;
            flagZ_q  <= 1'b0;
            flagN_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        opc_q   <= instr_i[OPC_MSB -: 3];
                        rd_q    <= instr_i[RD_MSB -: ADDR_W];
                        rs_q    <= instr_i[RS_MSB -: ADDR_W];
                        cin_q   <= instr_i[CIN_BIT];
                        busy_q  <= 1'b1;
                        state_q <= READ;
                    end
                end
                READ: begin
                    aluA_q   <= rdDataA;
                    aluB_q   <= rdDataB;
                    aluC_q   <= cin_q;
                    aluOpc_q <= opc_q;
                    state_q  <= EXEC;
                end
                EXEC: begin
                    // A NOP still walks the pipeline but leaves result and flags untouched.
                    if (opc_q != OP_NOP) begin
                        result_q <= aluW_i;
                        flagZ_q  <= aluZer_i;
                        flagN_q  <= aluNeg_i;
                    end
                    done_q  <= 1'b1;
                    state_q <= WB;
                end
                WB: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign aluA_o   = aluA_q;
    assign aluB_o   = aluB_q;
    assign aluC_o   = aluC_q;
    assign aluOpc_o = aluOpc_q;
    assign result_o = result_q;
    assign flagZ_o  = flagZ_q;
    assign flagN_o  = flagN_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Self-checking bench for alu_exec_ctrl: a behavioural ALU drives the DUT's
// ALU inputs, and a register-file/flag model predicts every observable output.
module tb_alu_exec_ctrl;

`ifdef ALU_EXEC_R0_ZERO_EN
    localparam bit R0_ZERO = 1'b1;
`else
    localparam bit R0_ZERO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] instr;
    logic        busy;
    logic        done;
    logic        extWrEn;
    logic [2:0]  extWrAddr;
    logic [15:0] extWrData;
    logic [15:0] aluA;
    logic [15:0] aluB;
    logic        aluC;
    logic [2:0]  aluOpc;
    logic [15:0] aluW;
    logic        aluZer;
    logic        aluNeg;
    logic [15:0] result;
    logic        flagZ;
    logic        flagN;

    int compareCount  = 0;
    int mismatchCount = 0;

    logic [15:0] modelRf [8];
    logic [15:0] modelResult;
    logic        modelZ;
    logic        modelN;

    always #5 clk = ~clk;

    // The ALU the parent would instantiate: 000 neg, 001 inc, 010 add+cin, 011 sub,
    // 100 and, 101 or, 110 pack low bytes, 111 nop.
    function automatic logic [15:0] aluFn(input logic [2:0] op, input logic [15:0] a,
                                          input logic [15:0] b, input logic c);
        case (op)
            3'd0:    return 16'd0 - a;
            3'd1:    return a + 16'd1;
            3'd2:    return a + b + {15'd0, c};
            3'd3:    return a - b;
            3'd4:    return a & b;
            3'd5:    return a | b;
            3'd6:    return {a[7:0], b[7:0]};
            default: return a;
        endcase
    endfunction

    assign aluW   = aluFn(aluOpc, aluA, aluB, aluC);
    assign aluZer = (aluW == 16'd0);
    assign aluNeg = aluW[15];

    alu_exec_ctrl dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .instr_i     (instr),
        .busy_o      (busy),
        .done_o      (done),
        .extWrEn_i   (extWrEn),
        .extWrAddr_i (extWrAddr),
        .extWrData_i (extWrData),
        .aluA_o      (aluA),
        .aluB_o      (aluB),
        .aluC_o      (aluC),
        .aluOpc_o    (aluOpc),
        .aluW_i      (aluW),
        .aluZer_i    (aluZer),
        .aluNeg_i    (aluNeg),
        .result_o    (result),
        .flagZ_o     (flagZ),
        .flagN_o     (flagN)
    );

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] mkInstr(input logic [2:0] op, input logic [2:0] rd,
                                            input logic [2:0] rs, input logic cin);
        return {op, rd, rs, cin, 6'b0};
    endfunction

    function automatic logic [15:0] modelRead(input logic [2:0] addr);
        if (R0_ZERO && addr == 3'd0) return 16'd0;
        return modelRf[addr];
    endfunction

    task automatic modelWrite(input logic [2:0] addr, input logic [15:0] data);
        if (!(R0_ZERO && addr == 3'd0)) modelRf[addr] = data;
    endtask

    task automatic modelReset();
        for (int i = 0; i < 8; i++) modelRf[i] = 16'd0;
        modelResult = 16'd0;
        modelZ = 1'b0;
        modelN = 1'b0;
    endtask

    task automatic extWrite(input logic [2:0] addr, input logic [15:0] data);
        extWrEn   = 1'b1;
        extWrAddr = addr;
        extWrData = data;
        tick();
        extWrEn = 1'b0;
        modelWrite(addr, data);
    endtask

    // Issues one instruction from IDLE and checks every cycle through to the
    // following IDLE. withWr adds a simultaneous external write; disturb pokes
    // start and extWrEn during READ, both of which must be ignored.
    task automatic applyStimulus(input logic [15:0] ins, input bit withWr,
                                 input logic [2:0] wa, input logic [15:0] wd,
                                 input bit disturb);
        logic [2:0]  op;
        logic [2:0]  rd;
        logic [2:0]  rs;
        logic        cin;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] w;
        op  = ins[15:13];
        rd  = ins[12:10];
        rs  = ins[9:7];
        cin = ins[6];
        start = 1'b1;
        instr = ins;
        if (withWr) begin
            extWrEn   = 1'b1;
            extWrAddr = wa;
            extWrData = wd;
            modelWrite(wa, wd);
        end
        a = modelRead(rd);
        b = modelRead(rs);
        tick();
        start   = 1'b0;
        extWrEn = 1'b0;
        checkOutput("busyRead", {15'd0, busy}, 16'd1);
        checkOutput("doneRead", {15'd0, done}, 16'd0);
        if (disturb) begin
            start     = 1'b1;
            instr     = ~ins;
            extWrEn   = 1'b1;
            extWrAddr = wa;
            extWrData = ~wd;
        end
        tick();
        start   = 1'b0;
        extWrEn = 1'b0;
        checkOutput("busyExec", {15'd0, busy}, 16'd1);
        checkOutput("doneExec", {15'd0, done}, 16'd0);
        tick();
        if (op != 3'b111) begin
            w = aluFn(op, a, b, cin);
            modelResult = w;
            modelZ = (w == 16'd0);
            modelN = w[15];
        end
        checkOutput("doneWb", {15'd0, done}, 16'd1);
        checkOutput("busyWb", {15'd0, busy}, 16'd1);
        checkOutput("aluA", aluA, a);
        checkOutput("aluB", aluB, b);
        checkOutput("aluC", {15'd0, aluC}, {15'd0, cin});
        checkOutput("aluOpc", {13'd0, aluOpc}, {13'd0, op});
        checkOutput("result", result, modelResult);
        checkOutput("flagZ", {15'd0, flagZ}, {15'd0, modelZ});
        checkOutput("flagN", {15'd0, flagN}, {15'd0, modelN});
        tick();
        if (op != 3'b111) modelWrite(rd, modelResult);
        checkOutput("doneIdle", {15'd0, done}, 16'd0);
        checkOutput("busyIdle", {15'd0, busy}, 16'd0);
    endtask

    initial begin
        logic [31:0] rnd;
        logic [15:0] ins;

        rst = 1'b1;
        start = 1'b0;
        instr = 16'd0;
        extWrEn = 1'b0;
        extWrAddr = 3'd0;
        extWrData = 16'd0;
        modelReset();
        repeat (2) tick();
        rst = 1'b0;

        checkOutput("rstBusy", {15'd0, busy}, 16'd0);
        checkOutput("rstDone", {15'd0, done}, 16'd0);
        checkOutput("rstResult", result, 16'd0);
        checkOutput("rstFlagZ", {15'd0, flagZ}, 16'd0);
        checkOutput("rstFlagN", {15'd0, flagN}, 16'd0);
        checkOutput("rstAluA", aluA, 16'd0);
        tick();
        checkOutput("idleBusy", {15'd0, busy}, 16'd0);
        for (int r = 0; r < 8; r += 2) begin
            applyStimulus(mkInstr(3'b111, 3'(r), 3'(r + 1), 1'b0), 1'b0, 3'd0, 16'd0, 1'b0);
        end

        extWrite(3'd1, 16'h0003);
        extWrite(3'd2, 16'h0004);
        applyStimulus(mkInstr(3'b010, 3'd1, 3'd2, 1'b1), 1'b0, 3'd0, 16'd0, 1'b0);
        checkOutput("addResult", result, 16'h0008);
        applyStimulus(mkInstr(3'b111, 3'd1, 3'd2, 1'b0), 1'b0, 3'd0, 16'd0, 1'b0);
        checkOutput("addWriteback", aluA, 16'h0008);

        extWrite(3'd3, 16'h0001);
        applyStimulus(mkInstr(3'b000, 3'd3, 3'd3, 1'b0), 1'b0, 3'd0, 16'd0, 1'b0);
        checkOutput("negResult", result, 16'hFFFF);
        checkOutput("negFlagN", {15'd0, flagN}, 16'd1);
        extWrite(3'd4, 16'h0000);
        applyStimulus(mkInstr(3'b000, 3'd4, 3'd4, 1'b0), 1'b0, 3'd0, 16'd0, 1'b0);
        checkOutput("negZeroFlagZ", {15'd0, flagZ}, 16'd1);

        extWrite(3'd5, 16'hAB12);
        extWrite(3'd6, 16'hCD34);
        applyStimulus(mkInstr(3'b110, 3'd5, 3'd6, 1'b0), 1'b0, 3'd6, 16'h0F0F, 1'b1);
        checkOutput("packResult", result, 16'h1234);
        tick();
        checkOutput("packNoSecondDone", {15'd0, done}, 16'd0);
        checkOutput("packNoQueuedStart", {15'd0, busy}, 16'd0);
        applyStimulus(mkInstr(3'b111, 3'd5, 3'd6, 1'b0), 1'b0, 3'd0, 16'd0, 1'b0);
        checkOutput("packR6Kept", aluB, 16'hCD34);

        // Reset lands while the INC is in EXEC; nothing may be written back.
        start = 1'b1;
        instr = mkInstr(3'b001, 3'd5, 3'd5, 1'b0);
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        modelReset();
        checkOutput("abortBusy", {15'd0, busy}, 16'd0);
        checkOutput("abortDone", {15'd0, done}, 16'd0);
        checkOutput("abortResult", result, 16'd0);
        tick();
        checkOutput("abortNoDone", {15'd0, done}, 16'd0);
        applyStimulus(mkInstr(3'b111, 3'd5, 3'd6, 1'b0), 1'b0, 3'd0, 16'd0, 1'b0);

        extWrite(3'd0, 16'h5555);
        applyStimulus(mkInstr(3'b001, 3'd0, 3'd0, 1'b0), 1'b0, 3'd0, 16'd0, 1'b0);
        checkOutput("r0IncResult", result, R0_ZERO ? 16'h0001 : 16'h5556);
        applyStimulus(mkInstr(3'b111, 3'd0, 3'd0, 1'b0), 1'b0, 3'd0, 16'd0, 1'b0);
        checkOutput("r0Readback", aluA, R0_ZERO ? 16'h0000 : 16'h5556);

        for (int it = 0; it < 80; it++) begin
            rnd = $urandom;
            if (rnd[0]) extWrite(rnd[3:1], rnd[31:16]);
            rnd = $urandom;
            ins = rnd[15:0];
            if (rnd[20:19] == 2'b00) ins[15:13] = 3'b111;
            applyStimulus(ins, rnd[17:16] == 2'b00, rnd[23:21], $urandom_range(0, 65535),
                          rnd[25:24] == 2'b00);
            if (rnd[26]) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
